// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Opcode and state encodings plus flag bit positions shared
//               by the sequential arithmetic unit and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  // 101..111 are not listed and decode as illegal.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NEG = 3'b010,
    OP_CMP = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_A_BIGGER = 3;
  localparam int FLAG_B_BIGGER = 4;
  localparam int FLAG_A_EQ_B   = 5;
  localparam int FLAG_ILLEGAL  = 6;
  localparam int FLAG_W        = 7;

endpackage
`default_nettype wire

// File: rtl/arith_unit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit_seq_if
// Description : Operand/result handshake bundle of the arithmetic unit.
//               master = producer/consumer side, slave = arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface arith_unit_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [6:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, flags
  );
endinterface
`default_nettype wire

// File: rtl/arith_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : arith_mul_seq
// Description : Iterative shift-add multiplier, one multiplier bit per cycle.
//               'done' is high during the final iteration cycle and 'product'
//               presents the accumulator value that iteration produces, so
//               the parent can capture the full product on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = (count == CW'(1));
  assign product  = acc_next;

  // Load operands on start, then add-and-shift until the bit counter empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CW'(WIDTH);
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit_seq
// Description : Handshaked arithmetic unit (ADD/SUB/NEG/CMP, optional MUL)
//               with IDLE/BUSY/DONE control. Single-cycle ops finish on the
//               accept edge; MUL runs through the iterative multiplier.
//               Build macro ARITH_UNIT_MUL_EN enables the multiplier; without
//               it opcode 100 decodes as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  arith_unit_seq_if.slave  bus
);
  localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               MSB      = WIDTH - 1;

  state_e               state;
  state_e               state_next;
  logic                 accept;
  logic                 is_mul;
  logic [WIDTH-1:0]     alu_res;
  logic [FLAG_W-1:0]    alu_flags;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     result_reg;
  logic [WIDTH-1:0]     result_hi_reg;
  logic [FLAG_W-1:0]    flags_reg;

  assign accept          = (state == ST_IDLE) && bus.in_valid;
  assign bus.result      = result_reg;
  assign bus.result_hi   = result_hi_reg;
  assign bus.flags       = flags_reg;

`ifdef ARITH_UNIT_MUL_EN
  assign is_mul = (bus.op == OP_MUL);

  arith_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle datapath: result and flags for the operands on the bus now.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    alu_flags[FLAG_A_BIGGER] = (bus.a >  bus.b);
    alu_flags[FLAG_B_BIGGER] = (bus.a <  bus.b);
    alu_flags[FLAG_A_EQ_B]   = (bus.a == bus.b);
    case (bus.op)
      OP_ADD: begin
        {alu_flags[FLAG_CARRY], alu_res} = {1'b0, bus.a} + {1'b0, bus.b};
        alu_flags[FLAG_OVERFLOW] = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
        alu_flags[FLAG_ZERO]     = (alu_res == '0);
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_flags[FLAG_CARRY]    = (bus.a < bus.b);
        alu_flags[FLAG_OVERFLOW] = (bus.a[MSB] != bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
        alu_flags[FLAG_ZERO]     = (alu_res == '0);
      end
      OP_NEG: begin
        alu_res = {WIDTH{1'b0}} - bus.b;
        alu_flags[FLAG_CARRY]    = (bus.b == '0);
        alu_flags[FLAG_OVERFLOW] = (bus.b == SIGN_MIN);
        alu_flags[FLAG_ZERO]     = (alu_res == '0);
      end
      OP_CMP: begin
        alu_flags[FLAG_ZERO] = (bus.a == bus.b);
      end
      default: begin
        // MUL (when built in) only seeds compare flags here; the rest
        // arrive from the multiplier at completion.
        alu_flags[FLAG_ILLEGAL] = !is_mul;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = is_mul ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (mul_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result registers: written on accept and on multiplier completion only,
  // so bus activity at other times cannot disturb a pending or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
    end else if (accept) begin
      result_reg    <= alu_res;
      result_hi_reg <= '0;
      flags_reg     <= alu_flags;
    end else if ((state == ST_BUSY) && mul_done) begin
      result_reg                <= mul_prod[WIDTH-1:0];
      result_hi_reg             <= mul_prod[2*WIDTH-1:WIDTH];
      flags_reg[FLAG_CARRY]     <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
      flags_reg[FLAG_OVERFLOW]  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
      flags_reg[FLAG_ZERO]      <= (mul_prod == '0);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit_seq
// Description : Self-checking bench: directed corner cases, reset abort and
//               randomized operations compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_seq;
  import arith_pkg::*;

  localparam int WIDTH = 8;
`ifdef ARITH_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  arith_unit_seq_if #(.WIDTH(WIDTH)) bus ();

  arith_unit_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {flags[22:16], result_hi[15:8], result[7:0]} from plain integer math.
  function automatic logic [22:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, s;
    logic [7:0] res, hi;
    logic c, v, z, ill;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    res = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0; z = 1'b0; ill = 1'b0;
    case (op)
      3'd0: begin s = ua + ub; res = 8'(s); c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin s = ua - ub; res = 8'(s); c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: begin res = 8'(-ub); c = (ub == 0); v = (-sb > 127); end
      3'd3: begin res = 8'h00; end
      3'd4: begin
        if (MUL_EN) begin
          s = ua * ub; res = 8'(s); hi = 8'(s / 256); c = (s > 255); v = (s > 255);
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (op == 3'd3) z = (ua == ub);
    else if (ill)   z = 1'b0;
    else            z = (res == 8'h00) && (hi == 8'h00);
    return {ill, (ua == ub), (ub > ua), (ua > ub), z, v, c, hi, res};
  endfunction

  task automatic scramble();
    bus.a  = 8'($urandom);
    bus.b  = 8'($urandom);
    bus.op = 3'($urandom);
  endtask

  // One transaction: accept, check latency and busy behaviour, check the
  // held result over 'hold' stall cycles, then release it.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [22:0] exp;
    int lat, exp_lat;
    exp     = model(op, a, b);
    exp_lat = (MUL_EN && op == 3'd4) ? WIDTH + 1 : 1;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!bus.out_valid && lat < 4 * WIDTH) begin
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      scramble();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid",     32'(bus.out_valid), 32'd1);
      chk("in_ready_done", 32'(bus.in_ready),  32'd0);
      chk("result",        32'(bus.result),    32'(exp[7:0]));
      chk("result_hi",     32'(bus.result_hi), 32'(exp[15:8]));
      chk("flags",         32'(bus.flags),     32'(exp[22:16]));
      if (i < hold) begin
        @(negedge clk);
        scramble();
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("in_ready_back",  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_result",    32'(bus.result),    32'd0);
    chk("rst_result_hi", 32'(bus.result_hi), 32'd0);
    chk("rst_flags",     32'(bus.flags),     32'd0);
    rst = 1'b0;

    run_op(OP_ADD, 8'hFF, 8'h01, 0);
    run_op(OP_ADD, 8'h7F, 8'h01, 1);
    run_op(OP_SUB, 8'h03, 8'h05, 0);
    run_op(OP_MUL, 8'h10, 8'h20, 0);
    run_op(OP_NEG, 8'h00, 8'h80, 5);
    run_op(OP_MUL, 8'h02, 8'h03, 0);
    run_op(3'b111, 8'h44, 8'h12, 0);
    run_op(OP_NEG, 8'h12, 8'h00, 0);

    // Reset in the middle of an operation (BUSY cycle 4 when MUL is built,
    // held result otherwise) with in_valid/out_ready also asserted.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'h5A; bus.b = 8'hC3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_flags",     32'(bus.flags),     32'd0);
    chk("abort_result",    32'(bus.result),    32'd0);
    chk("abort_result_hi", 32'(bus.result_hi), 32'd0);
    run_op(OP_CMP, 8'h33, 8'h33, 0);

    for (int n = 0; n < 150; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run_op(3'($urandom), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/arith_unit_seq.md
ARITH_UNIT_SEQ -- requirements
Module: arith_unit_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (2..32).
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  in  1  operand/opcode presented.
REQ-005 Port: in_ready  out  1  block accepts operands this cycle.
REQ-006 Port: op  in  3  opcode: 000 ADD, 001 SUB, 010 NEG, 011 CMP, 100 MUL; 101..111 illegal.
REQ-007 Port: a, b  in  WIDTH each  operands, unsigned for compare/carry, two's complement for overflow.
REQ-008 Port: out_valid  out  1  result and flags valid.
REQ-009 Port: out_ready  in  1  consumer takes result.
REQ-010 Port: result  out  WIDTH  low result word.
REQ-011 Port: result_hi  out  WIDTH  MUL upper word; 0 for all other ops.
REQ-012 Port: flags  out  7  {illegal, a_eq_b, b_bigger, a_bigger, zero, overflow, carry}, bit 0 = carry.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-014 in_ready SHALL be 1 exactly in IDLE; a transfer occurs when in_valid && in_ready, and a, b, op SHALL be captured then.
REQ-015 ADD, SUB, NEG, CMP and illegal ops SHALL go IDLE->DONE; result and flags registered on the accept edge, out_valid high the next cycle (latency 1).
REQ-016 MUL SHALL go IDLE->BUSY, iterate shift-add one multiplier bit per cycle for WIDTH cycles, then ->DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-017 In DONE, out_valid=1 and result/flags SHALL remain stable until out_ready=1; on that edge the FSM SHALL return to IDLE (no accept in the same cycle).
REQ-018 ADD: {carry,result}=a+b; SUB: result=a-b, carry=1 iff a<b unsigned (borrow); NEG: result=~b+1, carry=1 iff b==0.
REQ-019 overflow: ADD iff sign(a)==sign(b)!=sign(result); SUB iff sign(a)!=sign(b) and sign(result)!=sign(a); NEG iff b==100..0; MUL iff result_hi!=0 (carry equals overflow for MUL).
REQ-020 CMP SHALL set result=0, carry=0, overflow=0, zero=1 iff a==b.
REQ-021 zero SHALL be 1 iff result==0 and result_hi==0 (except CMP per REQ-020).
REQ-022 a_bigger, b_bigger, a_eq_b SHALL reflect unsigned compare of captured a, b for every op, exactly one set.
REQ-023 Illegal opcode: result=0, result_hi=0, illegal=1, all other flags 0 except compare flags.
REQ-024 Operand changes on a, b, op outside an accept edge SHALL NOT affect an in-flight or held result.

Reset
REQ-025 rst=1 SHALL force IDLE, out_valid=0, result=0, result_hi=0, flags=0 on the next edge, aborting any MUL in BUSY or held result in DONE.
REQ-026 rst SHALL override in_valid/out_ready presented in the same cycle.

Configuration
REQ-027 Macro ARITH_UNIT_MUL_EN defined: MUL implemented per REQ-016/019.
REQ-028 Macro undefined: no multiplier logic; op 100 SHALL be treated as illegal (REQ-023, latency 1); BUSY never entered.

Structure
REQ-029 Package arith_pkg SHALL hold the opcode enum (3-bit), state enum, and flag bit-index constants.
REQ-030 The iterative multiplier SHALL be sub-module arith_mul_seq (start, a, b -> done, product[2*WIDTH-1:0]), instantiated only under ARITH_UNIT_MUL_EN.

Verification (WIDTH=8)
REQ-031 ADD a=0xFF b=0x01 -> one cycle later result=0x00, carry=1, zero=1, overflow=0, a_bigger=1.
REQ-032 ADD a=0x7F b=0x01 -> result=0x80, overflow=1, carry=0; SUB a=0x03 b=0x05 -> result=0xFE, carry=1, b_bigger=1.
REQ-033 MUL a=0x10 b=0x20 (macro on) -> out_valid 9 cycles after accept, result=0x00, result_hi=0x02, overflow=1, carry=1; in_ready=0 throughout.
REQ-034 Hold out_ready=0 for 5 cycles after NEG b=0x80 -> result=0x80, overflow=1 held stable; in_ready=0 until cycle after out_ready=1.
REQ-035 Assert rst during BUSY cycle 4 -> next cycle IDLE, out_valid=0, flags=0; subsequent CMP a=b=0x33 -> zero=1, a_eq_b=1, result=0.
REQ-036 Macro off: op=100 a=0x02 b=0x03 -> latency 1, illegal=1, result=0, result_hi=0.
